map_seq_ctrl: RTL and testbench
===============================

MAP_SEQ_CTRL -- requirements
Module: map_seq_ctrl

Interface
REQ-001 Parameter GAP_CYC, default 4: idle cycles between consecutive OFDM symbols, legal range 1..15.
REQ-002 clk  in  1  single clock for all logic (sample rate of the bit stream).
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 start  in  1  one-cycle packet start request.
REQ-005 abort  in  1  one-cycle packet abort request.
REQ-006 rate_type  in  2  data-field modulation: 00 BPSK, 01 QPSK, 10 16-QAM, 11 64-QAM.
REQ-007 n_sym  in  8  number of DATA symbols after SIGNAL; 0 is legal.
REQ-008 bit_vld  in  1  upstream has a coded bit on bit_in.
REQ-009 bit_in  in  1  coded bit from the interleaver.
REQ-010 bit_rdy  out  1  controller accepts bit_in this cycle.
REQ-011 map_type  out  2  modulation select to the mapper.
REQ-012 map_din  out  1  bit to the mapper.
REQ-013 map_en  out  1  map_din valid.
REQ-014 tx_clr  out  1  one-cycle clear pulse to the mapper.
REQ-015 sym_start  out  1  one-cycle pulse on the first accepted bit of each symbol.
REQ-016 sym_idx  out  8  current symbol: 0 = SIGNAL, k = DATA symbol k.
REQ-017 busy  out  1  packet in progress.
REQ-018 done  out  1  one-cycle pulse at normal packet completion.

Function
REQ-019 The states SHALL be IDLE, SIG, GAP, DATA and DONE.
REQ-020 In IDLE, start SHALL latch rate_type and n_sym, pulse tx_clr on the next cycle, and move to SIG.
REQ-021 A start received outside IDLE SHALL be ignored.
REQ-022 Bits per symbol SHALL be 48 (BPSK, also used for SIG), 96 (QPSK), 192 (16-QAM) and 288 (64-QAM).
- The bit counter SHALL be 9 bits wide.
REQ-023 bit_rdy SHALL be high only in SIG and DATA, combinationally.
- A bit is accepted when bit_vld and bit_rdy are both high.
REQ-024 Each accepted bit SHALL appear on map_din with map_en=1 one cycle later, registered.
- Bits SHALL be passed in order and never dropped or duplicated.
- map_en SHALL be 0 on every other cycle.
REQ-025 map_type SHALL be 00 in IDLE and SIG, and SHALL equal the latched rate_type in DATA.
- map_type SHALL change only in GAP or IDLE, and only when no map_en is pending.
REQ-026 The bit counter SHALL increment on each accepted bit.
- On the last bit of a symbol the counter SHALL wrap to 0 and the FSM SHALL enter GAP.
- bit_vld low SHALL stall the counter without error.
REQ-027 GAP SHALL last exactly GAP_CYC cycles.
- GAP SHALL then go to DATA if sym_idx < latched n_sym, else to DONE.
- sym_idx SHALL increment on GAP exit into DATA.
REQ-028 DONE SHALL last one cycle, assert done, and return to IDLE.
REQ-029 busy SHALL be high in every state except IDLE.
REQ-030 sym_start SHALL pulse, aligned with map_en, on the first bit of every symbol.
REQ-031 abort in any non-IDLE state SHALL, on the next cycle: return the FSM to IDLE, pulse tx_clr, clear the counters and clear any pending map_en.
- done SHALL NOT pulse on abort.
- abort in IDLE SHALL be ignored.
REQ-032 Simultaneous start and abort in IDLE SHALL start the packet, because abort is ignored in IDLE.
REQ-033 n_sym=0 SHALL produce SIG, GAP, DONE only.
REQ-034 n_sym=255 SHALL complete 256 symbols without sym_idx wrapping.

Reset
REQ-035 While rst is high, all outputs SHALL be 0 and the FSM SHALL be in IDLE.
- This includes bit_rdy, map_en, tx_clr, sym_idx, busy and done.
REQ-036 Reset asserted mid-packet SHALL discard the packet.
- No done pulse SHALL be produced.
- After release, the block SHALL wait in IDLE for a new start.

Verification
REQ-037 Scenario: rate 10, n_sym=2, bit_vld held high, GAP_CYC=4.
- 48 map_en with map_type=00, then 4 idle cycles.
- 2 x 192 map_en with map_type=10, separated by 4 idle cycles.
- Then done, once.
- 3 sym_start pulses, with sym_idx 0, 1, 2.
REQ-038 Scenario: n_sym=0.
- 48 BPSK bits, 4-cycle gap, done.
- map_type never leaves 00.
REQ-039 Scenario: bit_vld toggling randomly, rate 11, n_sym=1.
- Exactly 48 + 288 map_en, in order.
- The map_din sequence equals the accepted bit_in sequence.
REQ-040 Scenario: abort at DATA bit 100.
- Next cycle: tx_clr=1, busy=0, bit_rdy=0.
- No further map_en and no done.
REQ-041 Scenario: start pulsed during SIG.
- Ignored; the packet completes normally, with one tx_clr at the original start.
REQ-042 Scenario: rst asserted mid-DATA.
- All outputs 0 immediately.
- After release, a new start runs a full packet correctly.

Source files
------------

// File: rtl/map_seq_ctrl.sv
// OFDM packet sequencer: steers coded bits from the interleaver into the mapper,
// one SIGNAL symbol then n_sym DATA symbols, with a fixed idle gap between symbols.
module map_seq_ctrl #(
    parameter int GAP_CYC = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic [1:0] rate_type,
    input  logic [7:0] n_sym,
    input  logic       bit_vld,
    input  logic       bit_in,
    output logic       bit_rdy,
    output logic [1:0] map_type,
    output logic       map_din,
    output logic       map_en,
    output logic       tx_clr,
    output logic       sym_start,
    output logic [7:0] sym_idx,
    output logic       busy,
    output logic       done
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_SIG  = 3'd1;
    localparam logic [2:0] S_GAP  = 3'd2;
    localparam logic [2:0] S_DATA = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [3:0] GAP_LAST = 4'(GAP_CYC - 1);

    logic [2:0] state_q, state_d;
    logic [1:0] rate_q, rate_d;
    logic [7:0] nsym_q, nsym_d;
    logic [8:0] bit_cnt_q, bit_cnt_d;
    logic [3:0] gap_cnt_q, gap_cnt_d;
    logic [7:0] sym_idx_q, sym_idx_d;
    logic [1:0] map_type_q, map_type_d;
    logic       map_din_q, map_din_d;
    logic       map_en_q, map_en_d;
    logic       sym_start_q, sym_start_d;
    logic       tx_clr_q, tx_clr_d;

    logic [8:0] sym_bits;
    logic       accept;
    logic       last_bit;

    assign bit_rdy = (state_q == S_SIG) || (state_q == S_DATA);
    assign accept  = bit_vld && bit_rdy;

    // SIGNAL is always BPSK regardless of the latched data rate
    always_comb begin
        sym_bits = 9'd48;
        if (state_q == S_DATA) begin
            case (rate_q)
                2'b00:   sym_bits = 9'd48;
                2'b01:   sym_bits = 9'd96;
                2'b10:   sym_bits = 9'd192;
                default: sym_bits = 9'd288;
            endcase
        end
    end

    assign last_bit = (bit_cnt_q == sym_bits - 9'd1);

    always_comb begin
        state_d     = state_q;
        rate_d      = rate_q;
        nsym_d      = nsym_q;
        bit_cnt_d   = bit_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        sym_idx_d   = sym_idx_q;
        map_type_d  = map_type_q;
        map_en_d    = accept;
        map_din_d   = accept ? bit_in : 1'b0;
        sym_start_d = accept && (bit_cnt_q == 9'd0);
        tx_clr_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    rate_d     = rate_type;
                    nsym_d     = n_sym;
                    state_d    = S_SIG;
                    tx_clr_d   = 1'b1;
                    bit_cnt_d  = 9'd0;
                    sym_idx_d  = 8'd0;
                    map_type_d = 2'b00;
                end
            end
            S_SIG, S_DATA: begin
                if (accept) begin
                    if (last_bit) begin
                        bit_cnt_d = 9'd0;
                        gap_cnt_d = 4'd0;
                        state_d   = S_GAP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 9'd1;
                    end
                end
            end
            S_GAP: begin
                // the mapper type only moves here, after the last bit has drained
                if (gap_cnt_q == GAP_LAST) begin
                    if (sym_idx_q < nsym_q) begin
                        state_d    = S_DATA;
                        sym_idx_d  = sym_idx_q + 8'd1;
                        map_type_d = rate_q;
                    end else begin
                        state_d = S_DONE;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q + 4'd1;
                end
            end
            S_DONE: begin
                state_d    = S_IDLE;
                sym_idx_d  = 8'd0;
                map_type_d = 2'b00;
            end
            default: state_d = S_IDLE;
        endcase

        if (abort && (state_q != S_IDLE)) begin
            state_d     = S_IDLE;
            tx_clr_d    = 1'b1;
            bit_cnt_d   = 9'd0;
            gap_cnt_d   = 4'd0;
            sym_idx_d   = 8'd0;
            map_type_d  = 2'b00;
            map_en_d    = 1'b0;
            map_din_d   = 1'b0;
            sym_start_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rate_q      <= 2'b00;
            nsym_q      <= 8'd0;
            bit_cnt_q   <= 9'd0;
            gap_cnt_q   <= 4'd0;
            sym_idx_q   <= 8'd0;
            map_type_q  <= 2'b00;
            map_din_q   <= 1'b0;
            map_en_q    <= 1'b0;
            sym_start_q <= 1'b0;
            tx_clr_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            rate_q      <= rate_d;
            nsym_q      <= nsym_d;
            bit_cnt_q   <= bit_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            sym_idx_q   <= sym_idx_d;
            map_type_q  <= map_type_d;
            map_din_q   <= map_din_d;
            map_en_q    <= map_en_d;
            sym_start_q <= sym_start_d;
            tx_clr_q    <= tx_clr_d;
        end
    end

    assign map_type  = map_type_q;
    assign map_din   = map_din_q;
    assign map_en    = map_en_q;
    assign sym_start = sym_start_q;
    assign tx_clr    = tx_clr_q;
    assign sym_idx   = sym_idx_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_map_seq_ctrl.sv
// Scoreboard bench for map_seq_ctrl: the driver queues every expected mapper beat,
// a negedge monitor pops and compares each map_en beat independently.
module tb_map_seq_ctrl;

    localparam int GAP = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [1:0] rate_type = 2'b00;
    logic [7:0] n_sym = 8'd0;
    logic       bit_vld = 1'b0;
    logic       bit_in = 1'b0;
    logic       bit_rdy;
    logic [1:0] map_type;
    logic       map_din;
    logic       map_en;
    logic       tx_clr;
    logic       sym_start;
    logic [7:0] sym_idx;
    logic       busy;
    logic       done;

    map_seq_ctrl #(.GAP_CYC(GAP)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .rate_type(rate_type), .n_sym(n_sym), .bit_vld(bit_vld), .bit_in(bit_in),
        .bit_rdy(bit_rdy), .map_type(map_type), .map_din(map_din), .map_en(map_en),
        .tx_clr(tx_clr), .sym_start(sym_start), .sym_idx(sym_idx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       b;
        logic [1:0] mt;
        logic       ss;
        logic [7:0] si;
        int         dl;   // required cycles since previous beat, 0 = unchecked
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   last_en_cyc = 0;
    int   done_cnt = 0;
    int   clr_cnt = 0;
    bit   sb_ignore = 1'b0;
    bit   acc_pending = 1'b0;
    bit   src_en = 1'b0;
    bit   rand_vld = 1'b0;
    int   src_idx = 0;
    logic stream [0:16383];

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int bps(input logic [1:0] r);
        case (r)
            2'b00:   return 48;
            2'b01:   return 96;
            2'b10:   return 192;
            default: return 288;
        endcase
    endfunction

    // bit source: presents stream[src_idx], advances only on a handshake
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (acc_pending) src_idx++;
            bit_vld = src_en && (!rand_vld || ($urandom_range(0, 1) == 1));
            bit_in  = stream[src_idx];
        end
    end

    // monitor
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                acc_pending = 1'b0;
            end else begin
                acc_pending = bit_vld && bit_rdy;
                done_cnt += int'(done);
                clr_cnt  += int'(tx_clr);
                if (map_en && !sb_ignore) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_map_en", 1, 0);
                    end else begin
                        mon_e = exp_q.pop_front();
                        chk("map_din", int'(map_din), int'(mon_e.b));
                        chk("map_type", int'(map_type), int'(mon_e.mt));
                        chk("sym_start", int'(sym_start), int'(mon_e.ss));
                        if (mon_e.ss) chk("sym_idx", int'(sym_idx), int'(mon_e.si));
                        if (mon_e.dl != 0) chk("beat_spacing", cyc - last_en_cyc, mon_e.dl);
                    end
                    last_en_cyc = cyc;
                end
            end
        end
    end

    task automatic run_pkt(input logic [1:0] r, input logic [7:0] ns, input bit rnd,
                           input bit abort_with_start, input bit mid_start, input int abort_at);
        int total, nexp, k, nb, d0, c0, budget;
        bit got;
        exp_t e;
        total = 48 + int'(ns) * bps(r);
        for (int i = 0; i < total; i++) stream[i] = 1'($urandom_range(0, 1));
        nexp = (abort_at >= 0) ? abort_at : total;
        k = 0;
        for (int s = 0; s <= int'(ns); s++) begin
            nb = (s == 0) ? 48 : bps(r);
            for (int j = 0; j < nb; j++) begin
                if (k < nexp) begin
                    e.b  = stream[k];
                    e.mt = (s == 0) ? 2'b00 : r;
                    e.ss = (j == 0);
                    e.si = 8'(s);
                    e.dl = (rnd || k == 0) ? 0 : ((j == 0) ? GAP + 1 : 1);
                    exp_q.push_back(e);
                end
                k++;
            end
        end
        d0 = done_cnt;
        c0 = clr_cnt;
        @(posedge clk); #2;
        src_idx = 0; rand_vld = rnd; src_en = 1'b1;
        start = 1'b1; abort = abort_with_start; rate_type = r; n_sym = ns;
        @(posedge clk); #2;
        start = 1'b0; abort = 1'b0; rate_type = ~r; n_sym = 8'hAA;
        @(negedge clk);
        chk("tx_clr_after_start", int'(tx_clr), 1);
        chk("busy_after_start", int'(busy), 1);
        if (mid_start) begin
            repeat (10) @(posedge clk);
            #2; start = 1'b1; rate_type = 2'b11; n_sym = 8'd5;
            @(posedge clk); #2; start = 1'b0; rate_type = ~r;
        end
        if (abort_at >= 0) begin
            got = 1'b0;
            for (int c = 0; c < 4 * total + 200 && !got; c++) begin
                @(posedge clk); #2;
                if (src_idx == abort_at) got = 1'b1;
            end
            chk("abort_point_reached", int'(got), 1);
            abort = 1'b1;
            @(posedge clk); #2;
            abort = 1'b0; src_en = 1'b0;
            @(negedge clk);
            chk("tx_clr_after_abort", int'(tx_clr), 1);
            chk("busy_after_abort", int'(busy), 0);
            chk("bit_rdy_after_abort", int'(bit_rdy), 0);
            chk("map_en_after_abort", int'(map_en), 0);
            repeat (20) @(posedge clk);
            chk("no_done_on_abort", done_cnt - d0, 0);
            chk("beats_left_after_abort", exp_q.size(), 0);
            chk("tx_clr_count_abort", clr_cnt - c0, 2);
            $display("pkt rate=%0d n_sym=%0d aborted after %0d bits", r, ns, abort_at);
            return;
        end
        budget = 3 * total + (int'(ns) + 1) * (GAP + 5) + 100;
        got = 1'b0;
        for (int c = 0; c < budget && !got; c++) begin
            @(posedge clk);
            if (done_cnt != d0) got = 1'b1;
        end
        chk("done_within_budget", int'(got), 1);
        src_en = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("done_count", done_cnt - d0, 1);
        chk("tx_clr_count", clr_cnt - c0, 1);
        chk("beats_left", exp_q.size(), 0);
        chk("busy_idle", int'(busy), 0);
        exp_q.delete();
        $display("pkt rate=%0d n_sym=%0d rnd=%0d bits=%0d complete", r, ns, rnd, total);
    endtask

    initial begin
        bit got;
        #1;
        chk("rst_bit_rdy", int'(bit_rdy), 0);
        chk("rst_map_en", int'(map_en), 0);
        chk("rst_tx_clr", int'(tx_clr), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_sym_idx", int'(sym_idx), 0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);

        run_pkt(2'b10, 8'd2, 1'b0, 1'b0, 1'b0, -1);   // nominal 16-QAM
        run_pkt(2'b01, 8'd1, 1'b0, 1'b1, 1'b0, -1);   // start with abort in IDLE
        run_pkt(2'b11, 8'd0, 1'b0, 1'b0, 1'b0, -1);   // SIGNAL only
        run_pkt(2'b11, 8'd1, 1'b1, 1'b0, 1'b0, -1);   // random bit_vld
        run_pkt(2'b10, 8'd2, 1'b0, 1'b0, 1'b0, 148);  // abort at DATA bit 100
        run_pkt(2'b01, 8'd1, 1'b0, 1'b0, 1'b1, -1);   // stray start during SIG

        // reset in the middle of DATA
        sb_ignore = 1'b1;
        for (int i = 0; i < 400; i++) stream[i] = 1'($urandom_range(0, 1));
        @(posedge clk); #2;
        src_idx = 0; rand_vld = 1'b0; src_en = 1'b1;
        start = 1'b1; rate_type = 2'b01; n_sym = 8'd3;
        @(posedge clk); #2 start = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 500 && !got; c++) begin
            @(posedge clk); #2;
            if (src_idx >= 100) got = 1'b1;
        end
        chk("reach_mid_data", int'(got), 1);
        rst = 1'b1;
        #1;
        chk("midrst_bit_rdy", int'(bit_rdy), 0);
        chk("midrst_map_en", int'(map_en), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_sym_idx", int'(sym_idx), 0);
        chk("midrst_map_type", int'(map_type), 0);
        chk("midrst_sym_start", int'(sym_start), 0);
        src_en = 1'b0;
        got = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        exp_q.delete();
        sb_ignore = 1'b0;
        repeat (5) @(negedge clk);
        chk("post_rst_idle", int'(busy), 0);
        $display("pkt rate=1 n_sym=3 discarded by reset");

        run_pkt(2'b00, 8'd3, 1'b0, 1'b0, 1'b0, -1);   // full packet after reset
        run_pkt(2'b00, 8'd255, 1'b0, 1'b0, 1'b0, -1); // 256 symbols

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
